// File: rtl/uart_tx_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_pkg
// Brief    : Register map, bit positions and FSM encoding for uart_tx_per.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_tx_pkg;

    localparam logic [1:0] c_OFF_TXDATA  = 2'd0;
    localparam logic [1:0] c_OFF_STATUS  = 2'd1;
    localparam logic [1:0] c_OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] c_OFF_CTRL    = 2'd3;

    localparam int c_ST_EMPTY   = 0;
    localparam int c_ST_FULL    = 1;
    localparam int c_ST_BUSY    = 2;
    localparam int c_ST_OVF     = 3;
    localparam int c_ST_CNT_LSB = 4;

    localparam int c_CTRL_TXEN = 0;
    localparam int c_CTRL_IE   = 1;
    localparam int c_CTRL_PAR  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_fifo
// Brief    : Small synchronous FIFO with combinational head and occupancy count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     mclk,
    input  logic                     puc_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam logic [c_PW:0] c_FULL_CNT = DEPTH[c_PW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge mclk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_FULL_CNT);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_tx_per.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_per
// Brief    : Peripheral-bus UART transmitter (8N1, FIFO-buffered, drain irq).
//            Define UART_TX_PARITY_EN to add an optional even-parity bit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_per
    import uart_tx_pkg::*;
#(
    parameter logic [13:0] BASE_ADDR   = 14'h08c,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        irq,
    input  logic        irqacc,
    output logic        txd
);

    localparam int c_CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t       r_state;
    logic [15:0]     r_baud_div;
    logic [15:0]     r_baud_cnt;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic            r_txd;
    logic            r_txen;
    logic            r_ie;
    logic            r_ovf;
    logic            r_irq;
`ifdef UART_TX_PARITY_EN
    logic            r_par_en;
    logic            r_parity;
`endif

    logic [13:0]     w_off;
    logic            w_hit;
    logic            w_wr;
    logic            w_rd;
    logic            w_wr_txdata;
    logic            w_push;
    logic            w_drop;
    logic            w_pop;
    logic            w_bit_end;
    logic            w_irq_set;
    logic [7:0]      w_head;
    logic            w_empty;
    logic            w_full;
    logic [c_CW-1:0] w_count;
    logic [15:0]     w_status;
    logic [15:0]     w_ctrl;

    // Subtraction keeps the decode correct for bases that are not 4-aligned.
    assign w_off       = per_addr - BASE_ADDR;
    assign w_hit       = per_en && (w_off[13:2] == 12'd0);
    assign w_wr        = w_hit && (per_we != 2'b00);
    assign w_rd        = w_hit && (per_we == 2'b00);
    assign w_wr_txdata = w_wr && (w_off[1:0] == c_OFF_TXDATA) && per_we[0];
    assign w_push      = w_wr_txdata && !w_full;
    assign w_drop      = w_wr_txdata && w_full;

    assign w_bit_end = (r_baud_cnt == 16'd0);
    assign w_pop     = r_txen && !w_empty &&
                       ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));
    assign w_irq_set = r_ie && w_empty && (r_state == ST_STOP) && w_bit_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .mclk      (mclk),
        .puc_rst_n (puc_rst_n),
        .i_push    (w_push),
        .i_wdata   (per_din[7:0]),
        .i_pop     (w_pop),
        .o_rdata   (w_head),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_count   (w_count)
    );

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_baud_div <= DEFAULT_DIV;
            r_txen     <= 1'b1;
            r_ie       <= 1'b0;
            r_ovf      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_en   <= 1'b0;
`endif
        end else begin
            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_wr && (w_off[1:0] == c_OFF_STATUS) && per_we[0] && per_din[3])
                r_ovf <= 1'b0;
            if (w_wr && (w_off[1:0] == c_OFF_BAUDDIV)) begin
                if (per_we[0]) r_baud_div[7:0]  <= per_din[7:0];
                if (per_we[1]) r_baud_div[15:8] <= per_din[15:8];
            end
            if (w_wr && (w_off[1:0] == c_OFF_CTRL) && per_we[0]) begin
                r_txen   <= per_din[c_CTRL_TXEN];
                r_ie     <= per_din[c_CTRL_IE];
`ifdef UART_TX_PARITY_EN
                r_par_en <= per_din[c_CTRL_PAR];
`endif
            end
        end
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_state    <= ST_IDLE;
            r_txd      <= 1'b1;
            r_shift    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_baud_cnt <= 16'd0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            if ((r_state != ST_IDLE) && !w_bit_end)
                r_baud_cnt <= r_baud_cnt - 16'd1;
            case (r_state)
                ST_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_shift    <= w_head;
                        r_baud_cnt <= r_baud_div;
                        r_txd      <= 1'b0;
                        r_state    <= ST_START;
`ifdef UART_TX_PARITY_EN
                        r_parity   <= even_parity(w_head);
`endif
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= r_baud_div;
                        r_txd      <= r_shift[0];
                        r_bit_cnt  <= 3'd0;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= r_baud_div;
                        if (r_bit_cnt == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= ST_STOP;
`ifdef UART_TX_PARITY_EN
                            if (r_par_en) begin
                                r_txd   <= r_parity;
                                r_state <= ST_PARITY;
                            end
`endif
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= r_baud_div;
                        r_txd      <= 1'b1;
                        r_state    <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= r_baud_div;
                        if (w_pop) begin
                            r_shift  <= w_head;
                            r_txd    <= 1'b0;
                            r_state  <= ST_START;
`ifdef UART_TX_PARITY_EN
                            r_parity <= even_parity(w_head);
`endif
                        end else begin
                            r_txd   <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A new drain event takes priority over a coincident acknowledge.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n)
            r_irq <= 1'b0;
        else if (w_irq_set)
            r_irq <= 1'b1;
        else if (irqacc)
            r_irq <= 1'b0;
    end

    always_comb begin
        w_status                     = 16'h0000;
        w_status[c_ST_EMPTY]         = w_empty;
        w_status[c_ST_FULL]          = w_full;
        w_status[c_ST_BUSY]          = (r_state != ST_IDLE);
        w_status[c_ST_OVF]           = r_ovf;
        w_status[c_ST_CNT_LSB +: 3]  = 3'(w_count);
    end

    always_comb begin
        w_ctrl              = 16'h0000;
        w_ctrl[c_CTRL_TXEN] = r_txen;
        w_ctrl[c_CTRL_IE]   = r_ie;
`ifdef UART_TX_PARITY_EN
        w_ctrl[c_CTRL_PAR]  = r_par_en;
`endif
    end

    always_comb begin
        per_dout = 16'h0000;
        if (w_rd) begin
            case (w_off[1:0])
                c_OFF_STATUS:  per_dout = w_status;
                c_OFF_BAUDDIV: per_dout = r_baud_div;
                c_OFF_CTRL:    per_dout = w_ctrl;
                default:       per_dout = 16'h0000;
            endcase
        end
    end

    assign txd = r_txd;
    assign irq = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_per.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_tx_per
// Brief    : Directed/randomized bench for uart_tx_per against a bit-stream model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_per;

    localparam logic [13:0] c_BASE = 14'h08c;
    localparam logic [1:0]  c_TXD = 2'd0, c_STS = 2'd1, c_BAUD = 2'd2, c_CTL = 2'd3;

    logic        mclk = 1'b0;
    logic        puc_rst_n = 1'b0;
    logic [13:0] per_addr = '0;
    logic [15:0] per_din = '0;
    logic        per_en = 1'b0;
    logic [1:0]  per_we = 2'b00;
    logic [15:0] per_dout;
    logic        irq;
    logic        irqacc = 1'b0;
    logic        txd;

    int n_cmp = 0;
    int n_err = 0;
    logic exp_q[$];

    uart_tx_per dut (
        .mclk      (mclk),
        .puc_rst_n (puc_rst_n),
        .per_addr  (per_addr),
        .per_din   (per_din),
        .per_en    (per_en),
        .per_we    (per_we),
        .per_dout  (per_dout),
        .irq       (irq),
        .irqacc    (irqacc),
        .txd       (txd)
    );

    always #5 mclk = ~mclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] off, input logic [15:0] d, input logic [1:0] we);
        @(negedge mclk);
        per_en = 1'b1; per_we = we; per_addr = c_BASE + 14'(off); per_din = d;
        @(posedge mclk);
        #1;
        per_en = 1'b0; per_we = 2'b00;
    endtask

    task automatic rd_chk(input string tag, input logic [13:0] addr, input logic [15:0] exp);
        @(negedge mclk);
        per_en = 1'b1; per_we = 2'b00; per_addr = addr;
        #1;
        check(tag, per_dout, exp);
        per_en = 1'b0;
    endtask

    task automatic sync_edge();
        @(posedge mclk);
        #1;
    endtask

    // Model: start(0), data LSB first, optional even parity, stop(1); each bit div+1 cycles.
    task automatic add_frame(input logic [7:0] b, input int div, input bit par);
        int nbits;
        logic bv;
        nbits = par ? 11 : 10;
        for (int k = 0; k < nbits; k++) begin
            if (k == 0)               bv = 1'b0;
            else if (k <= 8)          bv = b[k-1];
            else if (par && k == 9)   bv = 1'(($countones(b) % 2));
            else                      bv = 1'b1;
            for (int c = 0; c <= div; c++) exp_q.push_back(bv);
        end
    endtask

    // First posedge seen is the trigger edge; txd is checked from the following edge on.
    task automatic run_stream(input string tag, input int idle_after, input bit chk_busy);
        int n;
        n = exp_q.size();
        @(posedge mclk);
        for (int i = 0; i < n + idle_after; i++) begin
            @(posedge mclk);
            #1;
            if (i < n)
                check($sformatf("%s_txd%0d", tag, i), 16'(txd), 16'(exp_q[i]));
            else
                check($sformatf("%s_idle%0d", tag, i - n), 16'(txd), 16'h0001);
            if (chk_busy) begin
                per_en = 1'b1; per_we = 2'b00; per_addr = c_BASE + 14'(c_STS);
                #1;
                check($sformatf("%s_busy%0d", tag, i), 16'(per_dout[2]), (i < n) ? 16'h0001 : 16'h0000);
                per_en = 1'b0;
            end
        end
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b [6];
        int div;

        // Reset state
        repeat (3) @(posedge mclk);
        #1;
        check("rst_txd", 16'(txd), 16'h0001);
        check("rst_irq", 16'(irq), 16'h0000);
        check("rst_dout_idle", per_dout, 16'h0000);
        @(negedge mclk);
        puc_rst_n = 1'b1;
        rd_chk("rst_status", c_BASE + 14'(c_STS), 16'h0001);
        rd_chk("rst_bauddiv", c_BASE + 14'(c_BAUD), 16'd433);
        rd_chk("rst_ctrl", c_BASE + 14'(c_CTL), 16'h0001);
        rd_chk("rd_txdata", c_BASE, 16'h0000);
        rd_chk("rd_unmapped_hi", c_BASE + 14'd4, 16'h0000);
        rd_chk("rd_unmapped_lo", c_BASE - 14'd1, 16'h0000);

        // BAUDDIV byte lanes
        wr(c_BAUD, 16'h0003, 2'b11);
        wr(c_BAUD, 16'h12ff, 2'b10);
        rd_chk("baud_hi_lane", c_BASE + 14'(c_BAUD), 16'h1203);
        wr(c_BAUD, 16'hab03, 2'b01);
        rd_chk("baud_lo_lane", c_BASE + 14'(c_BAUD), 16'h1203);
        wr(c_BAUD, 16'h0003, 2'b11);

        // Single frame 0xA5 with busy tracking, then a random byte
        add_frame(8'ha5, 3, 1'b0);
        sync_edge();
        fork
            wr(c_TXD, 16'h00a5, 2'b01);
            run_stream("a5", 2, 1'b1);
        join
        b[0] = 8'($urandom_range(0, 255));
        add_frame(b[0], 3, 1'b0);
        sync_edge();
        fork
            wr(c_TXD, {8'h00, b[0]}, 2'b01);
            run_stream("rnd", 2, 1'b1);
        join

        // Random divider, including 0 (one cycle per bit)
        div = $urandom_range(0, 5);
        wr(c_BAUD, 16'(div), 2'b11);
        rd_chk("baud_rnd", c_BASE + 14'(c_BAUD), 16'(div));
        b[0] = 8'($urandom_range(0, 255));
        add_frame(b[0], div, 1'b0);
        sync_edge();
        fork
            wr(c_TXD, {8'h00, b[0]}, 2'b01);
            run_stream("div", 2, 1'b0);
        join
        wr(c_BAUD, 16'h0003, 2'b11);

        // Six back-to-back writes: one pops, four queue, sixth dropped
        for (int k = 0; k < 6; k++) b[k] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 5; k++) add_frame(b[k], 3, 1'b0);
        sync_edge();
        fork
            begin
                for (int k = 0; k < 6; k++) wr(c_TXD, {8'h00, b[k]}, 2'b01);
                rd_chk("b2b_status_full", c_BASE + 14'(c_STS), 16'h004e);
            end
            run_stream("b2b", 2, 1'b0);
        join
        rd_chk("b2b_status_ovf", c_BASE + 14'(c_STS), 16'h0009);
        wr(c_STS, 16'h0008, 2'b01);
        rd_chk("ovf_cleared", c_BASE + 14'(c_STS), 16'h0001);

        // Interrupt: set on drain, acknowledge, set-vs-ack, ie clear keeps pending
        wr(c_CTL, 16'h0003, 2'b01);
        add_frame(8'h3c, 3, 1'b0);
        sync_edge();
        fork
            wr(c_TXD, 16'h003c, 2'b01);
            run_stream("irq1", 0, 1'b0);
        join
        check("irq_before_idle", 16'(irq), 16'h0000);
        sync_edge();
        check("irq_on_idle", 16'(irq), 16'h0001);
        irqacc = 1'b1;
        sync_edge();
        irqacc = 1'b0;
        check("irq_acked", 16'(irq), 16'h0000);
        add_frame(8'hc3, 3, 1'b0);
        sync_edge();
        fork
            wr(c_TXD, 16'h00c3, 2'b01);
            run_stream("irq2", 0, 1'b0);
        join
        irqacc = 1'b1;
        sync_edge();
        irqacc = 1'b0;
        check("irq_set_wins", 16'(irq), 16'h0001);
        wr(c_CTL, 16'h0001, 2'b01);
        sync_edge();
        check("irq_ie_clear_keeps", 16'(irq), 16'h0001);
        irqacc = 1'b1;
        sync_edge();
        irqacc = 1'b0;
        check("irq_acked2", 16'(irq), 16'h0000);

        // txen cleared mid-frame with two bytes queued
        for (int k = 0; k < 3; k++) b[k] = 8'($urandom_range(0, 255));
        add_frame(b[0], 3, 1'b0);
        sync_edge();
        fork
            begin
                for (int k = 0; k < 3; k++) wr(c_TXD, {8'h00, b[k]}, 2'b01);
                repeat (10) @(posedge mclk);
                wr(c_CTL, 16'h0000, 2'b01);
            end
            run_stream("txen_off", 20, 1'b0);
        join
        rd_chk("txen_off_status", c_BASE + 14'(c_STS), 16'h0020);
        add_frame(b[1], 3, 1'b0);
        add_frame(b[2], 3, 1'b0);
        sync_edge();
        fork
            wr(c_CTL, 16'h0001, 2'b01);
            run_stream("txen_on", 2, 1'b0);
        join

        // Asynchronous reset mid-DATA
        sync_edge();
        wr(c_TXD, 16'h0000, 2'b01);
        wr(c_TXD, 16'h0055, 2'b01);
        wr(c_TXD, 16'h00aa, 2'b01);
        repeat (10) @(posedge mclk);
        #3;
        check("pre_rst_txd_low", 16'(txd), 16'h0000);
        puc_rst_n = 1'b0;
        #1;
        check("async_rst_txd", 16'(txd), 16'h0001);
        repeat (2) @(posedge mclk);
        @(negedge mclk);
        puc_rst_n = 1'b1;
        rd_chk("post_rst_status", c_BASE + 14'(c_STS), 16'h0001);
        rd_chk("post_rst_baud", c_BASE + 14'(c_BAUD), 16'd433);
        sync_edge();
        check("post_rst_txd", 16'(txd), 16'h0001);

        // Parity option
        wr(c_BAUD, 16'h0003, 2'b11);
        wr(c_CTL, 16'h0005, 2'b01);
`ifdef UART_TX_PARITY_EN
        rd_chk("ctrl_par", c_BASE + 14'(c_CTL), 16'h0005);
        add_frame(8'h07, 3, 1'b1);
        b[0] = 8'($urandom_range(0, 255));
        add_frame(b[0], 3, 1'b1);
        sync_edge();
        fork
            begin
                wr(c_TXD, 16'h0007, 2'b01);
                wr(c_TXD, {8'h00, b[0]}, 2'b01);
            end
            run_stream("par", 2, 1'b0);
        join
`else
        rd_chk("ctrl_par_ignored", c_BASE + 14'(c_CTL), 16'h0001);
        add_frame(8'h07, 3, 1'b0);
        sync_edge();
        fork
            wr(c_TXD, 16'h0007, 2'b01);
            run_stream("nopar", 2, 1'b0);
        join
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
